// File: rtl/aes_key_expand_ctrl.sv
// AES-128 key-expansion sequencer: drives the key schedule for rounds 1..10 and keeps all round keys.
// Optional stuck-schedule abort is compiled in with KEYEXP_WATCHDOG_EN.
module aes_key_expand_ctrl (
   input  logic         clk,
   input  logic         reset,
   input  logic         load_i,
   input  logic [127:0] key_i,
   output logic         busy_o,
   output logic         done_o,
   output logic         err_o,
   output logic         ks_start_o,
   output logic [3:0]   ks_round_o,
   output logic [127:0] ks_last_key_o,
   input  logic [127:0] ks_new_key_i,
   input  logic         ks_ready_i,
   input  logic [3:0]   rd_idx_i,
   input  logic         rd_rev_i,
   output logic [127:0] rd_key_o
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT
   } state_t;

   state_t         state_q, state_d;
   logic [127:0]   key_mem [0:10];
   logic [127:0]   last_q;
   logic [3:0]     round_q;
   logic           busy_q, done_q;
   logic           accept, capture, finish, abort;
   logic           wd_expired;
   logic [3:0]     eff_idx;

`ifdef KEYEXP_WATCHDOG_EN
   logic [3:0] wd_q;
   logic       err_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         wd_q  <= 4'd0;
         err_q <= 1'b0;
      end else begin
         if (state_q == ISSUE)
            wd_q <= 4'd0;
         else if (state_q == WAIT && !ks_ready_i)
            wd_q <= wd_q + 4'd1;
         if (accept)
            err_q <= 1'b0;
         else if (abort)
            err_q <= 1'b1;
      end
   end

   assign wd_expired = (wd_q == 4'hf);
   assign err_o      = err_q;
`else
   assign wd_expired = 1'b0;
   assign err_o      = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      capture = 1'b0;
      finish  = 1'b0;
      abort   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (load_i) begin
               accept  = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: state_d = WAIT;
         WAIT: begin
            if (ks_ready_i) begin
               capture = 1'b1;
               if (round_q == 4'd10) begin
                  finish  = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = ISSUE;
               end
            end else if (wd_expired) begin
               abort   = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         last_q  <= '0;
         round_q <= 4'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         for (int i = 0; i < 11; i++)
            key_mem[i] <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            key_mem[0] <= key_i;
            last_q     <= key_i;
            round_q    <= 4'd1;
            done_q     <= 1'b0;
            busy_q     <= 1'b1;
         end
         if (capture) begin
            for (int i = 1; i < 11; i++)
               if (round_q == 4'(i))
                  key_mem[i] <= ks_new_key_i;
            last_q <= ks_new_key_i;
            if (!finish)
               round_q <= round_q + 4'd1;
         end
         if (finish) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
         end
         if (abort)
            busy_q <= 1'b0;
      end
   end

   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign ks_start_o    = (state_q == ISSUE);
   assign ks_round_o    = round_q;
   assign ks_last_key_o = last_q;

   // Reverse order serves decryption, which walks the schedule from round 10 down.
   assign eff_idx = rd_rev_i ? (4'd10 - rd_idx_i) : rd_idx_i;

   always_comb begin
      rd_key_o = '0;
      if (rd_idx_i <= 4'd10)
         rd_key_o = key_mem[eff_idx];
   end

endmodule

// File: tb/tb_aes_key_expand_ctrl.sv
// Bench for aes_key_expand_ctrl with a behavioural 5-cycle AES-128 key schedule attached.
// Watchdog checks follow KEYEXP_WATCHDOG_EN.
module tb_aes_key_expand_ctrl;

   logic         clk = 1'b0;
   logic         reset;
   logic         load_i;
   logic [127:0] key_i;
   logic         busy_o, done_o, err_o, ks_start_o;
   logic [3:0]   ks_round_o;
   logic [127:0] ks_last_key_o, ks_new_key_i, rd_key_o;
   logic         ks_ready_i;
   logic [3:0]   rd_idx_i;
   logic         rd_rev_i;

   localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FIPS1 = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] FIPS10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

   int n_checks = 0;
   int n_fail = 0;
   int tcnt = 0;
   int t0 = 0;
   int unstable = 0;
   int start_t[$];
   logic [3:0]   sb_round[$];
   logic [127:0] sb_last[$];
   logic [127:0] sb_rd[$];
   logic [127:0] gold[0:10];
   logic [127:0] gold_b[0:10];

   logic         stray, ks_en;
   int           cnt = 0;
   logic [127:0] ks_hold = '0, ks_res = '0;

   always #5 clk = ~clk;

   aes_key_expand_ctrl dut (
      .clk(clk), .reset(reset), .load_i(load_i), .key_i(key_i),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
      .ks_start_o(ks_start_o), .ks_round_o(ks_round_o),
      .ks_last_key_o(ks_last_key_o), .ks_new_key_i(ks_new_key_i),
      .ks_ready_i(ks_ready_i), .rd_idx_i(rd_idx_i), .rd_rev_i(rd_rev_i),
      .rd_key_o(rd_key_o)
   );

   task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] xtime(logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = xtime(a);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox(logic [7:0] x);
      logic [7:0] b = 8'h01;
      for (int i = 0; i < 254; i++) b = gmul(b, x);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^
             {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] next_key(logic [127:0] k, logic [3:0] r);
      logic [7:0]  rc = 8'h01;
      logic [31:0] w0, w1, w2, w3, t;
      for (int i = 1; i < int'(r); i++) rc = xtime(rc);
      {w0, w1, w2, w3} = k;
      t = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
      t[31:24] = t[31:24] ^ rc;
      w0 = w0 ^ t;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   task automatic push_expected(logic [127:0] k);
      for (int r = 1; r <= 10; r++) begin
         sb_round.push_back(4'(r));
         sb_last.push_back(k);
         k = next_key(k, 4'(r));
      end
   endtask

   task automatic rd_check(string tag, int idx, bit rev, logic [127:0] exp);
      sb_rd.push_back(exp);
      rd_idx_i = 4'(idx);
      rd_rev_i = rev;
      #1;
      check(tag, rd_key_o, sb_rd.pop_front());
   endtask

   // Behavioural key schedule: ready five cycles after the start pulse.
   always @(posedge clk) begin
      if (reset) cnt <= 0;
      else if (cnt == 5) cnt <= 0;
      else if (cnt != 0) cnt <= cnt + 1;
      else if (ks_start_o && ks_en) begin
         cnt     <= 1;
         ks_hold <= ks_last_key_o;
         ks_res  <= next_key(ks_last_key_o, ks_round_o);
      end
   end

   assign ks_ready_i   = (cnt == 5) | stray;
   assign ks_new_key_i = ks_res;

   always @(posedge clk) begin
      tcnt <= tcnt + 1;
      if (ks_start_o) begin
         start_t.push_back(tcnt - t0);
         if (sb_round.size() == 0)
            check("start_extra", 128'd1, 128'd0);
         else begin
            check("ks_round", 128'(ks_round_o), 128'(sb_round.pop_front()));
            check("ks_last", ks_last_key_o, sb_last.pop_front());
         end
      end
      if (cnt != 0 && !reset && ks_last_key_o !== ks_hold)
         unstable++;
   end

   initial begin
      int n;
      reset = 1'b1; load_i = 1'b0; key_i = '0;
      rd_idx_i = '0; rd_rev_i = 1'b0; stray = 1'b0; ks_en = 1'b1;
      gold[0] = KEY_A;
      gold_b[0] = KEY_B;
      for (int r = 1; r <= 10; r++) begin
         gold[r] = next_key(gold[r-1], 4'(r));
         gold_b[r] = next_key(gold_b[r-1], 4'(r));
      end
      repeat (3) @(negedge clk);
      check("rst_busy", 128'(busy_o), 128'd0);
      check("rst_done", 128'(done_o), 128'd0);
      check("rst_err", 128'(err_o), 128'd0);
      check("rst_start", 128'(ks_start_o), 128'd0);
      check("rst_round", 128'(ks_round_o), 128'd0);
      check("rst_last", ks_last_key_o, 128'd0);
      rd_check("rst_rd", 0, 1'b0, 128'd0);
      reset = 1'b0;

      // Run 1: FIPS key, with an ignored load at cycle 20
      @(negedge clk);
      start_t.delete();
      t0 = tcnt; load_i = 1'b1; key_i = KEY_A;
      push_expected(KEY_A);
      for (int c = 1; c <= 61; c++) begin
         @(negedge clk);
         load_i = (c == 20);
         key_i = (c == 20) ? KEY_B : KEY_A;
         if (c == 1) check("busy_c1", 128'(busy_o), 128'd1);
         if (c == 60) begin
            check("busy_c60", 128'(busy_o), 128'd1);
            check("done_c60", 128'(done_o), 128'd0);
         end
         if (c == 61) begin
            check("done_c61", 128'(done_o), 128'd1);
            check("busy_c61", 128'(busy_o), 128'd0);
         end
      end
      check("start_cnt", 128'(start_t.size()), 128'd10);
      for (int i = 0; i < start_t.size() && i < 10; i++)
         check("start_cyc", 128'(start_t[i]), 128'(1 + 6 * i));
      check("last_stable", 128'(unstable), 128'd0);
      check("sb_empty", 128'(sb_round.size()), 128'd0);
      rd_check("fips_r1", 1, 1'b0, FIPS1);
      rd_check("fips_r10", 10, 1'b0, FIPS10);
      rd_check("fips_rev0", 0, 1'b1, FIPS10);
      for (int i = 0; i <= 10; i++) begin
         rd_check("rd_fwd", i, 1'b0, gold[i]);
         rd_check("rd_rev", i, 1'b1, gold[10 - i]);
      end

      // Run 2: reload after done
      @(negedge clk);
      load_i = 1'b1; key_i = KEY_B;
      push_expected(KEY_B);
      @(negedge clk);
      load_i = 1'b0;
      check("reload_done", 128'(done_o), 128'd0);
      check("reload_busy", 128'(busy_o), 128'd1);
      n = 0;
      while (!done_o && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("run2_done", 128'(done_o), 128'd1);
      rd_check("run2_r10", 10, 1'b0, gold_b[10]);
      rd_check("run2_rev3", 3, 1'b1, gold_b[7]);
      for (int i = 11; i <= 15; i++) begin
         rd_check("rd_oob", i, 1'b0, 128'd0);
         rd_check("rd_oob_rev", i, 1'b1, 128'd0);
      end

      // Run 3: reset at cycle 30
      @(negedge clk);
      load_i = 1'b1; key_i = KEY_A;
      push_expected(KEY_A);
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         load_i = 1'b0;
         if (c == 30) reset = 1'b1;
      end
      @(negedge clk);
      reset = 1'b0;
      sb_round.delete();
      sb_last.delete();
      check("mid_rst_busy", 128'(busy_o), 128'd0);
      check("mid_rst_done", 128'(done_o), 128'd0);
      check("mid_rst_start", 128'(ks_start_o), 128'd0);
      check("mid_rst_round", 128'(ks_round_o), 128'd0);
      check("mid_rst_last", ks_last_key_o, 128'd0);
      for (int i = 0; i <= 10; i++)
         rd_check("mid_rst_rd", i, 1'b0, 128'd0);
      @(negedge clk);
      stray = 1'b1;
      @(negedge clk);
      stray = 1'b0;
      @(negedge clk);
      check("stray_busy", 128'(busy_o), 128'd0);
      check("stray_start", 128'(ks_start_o), 128'd0);
      check("stray_round", 128'(ks_round_o), 128'd0);
      check("stray_last", ks_last_key_o, 128'd0);
      rd_check("stray_rd", 1, 1'b0, 128'd0);

      // Dead key schedule
      ks_en = 1'b0;
      load_i = 1'b1; key_i = KEY_B;
      push_expected(KEY_B);
`ifdef KEYEXP_WATCHDOG_EN
      for (int c = 1; c <= 18; c++) begin
         @(negedge clk);
         load_i = 1'b0;
         if (c == 17) begin
            check("wd_busy17", 128'(busy_o), 128'd1);
            check("wd_err17", 128'(err_o), 128'd0);
         end
         if (c == 18) begin
            check("wd_err", 128'(err_o), 128'd1);
            check("wd_busy", 128'(busy_o), 128'd0);
            check("wd_done", 128'(done_o), 128'd0);
         end
      end
      sb_round.delete();
      sb_last.delete();
      ks_en = 1'b1;
      load_i = 1'b1; key_i = KEY_A;
      push_expected(KEY_A);
      @(negedge clk);
      load_i = 1'b0;
      check("wd_err_clr", 128'(err_o), 128'd0);
      n = 0;
      while (!done_o && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("wd_reload_done", 128'(done_o), 128'd1);
      check("wd_reload_err", 128'(err_o), 128'd0);
      rd_check("wd_reload_r10", 10, 1'b0, FIPS10);
`else
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         load_i = 1'b0;
      end
      check("nowd_busy", 128'(busy_o), 128'd1);
      check("nowd_err", 128'(err_o), 128'd0);
      check("nowd_done", 128'(done_o), 128'd0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      sb_round.delete();
      sb_last.delete();
      ks_en = 1'b1;
`endif
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
